// File: rtl/axi_lite_router_pkg.sv
// Shared types and constants for the AXI-Lite 1-to-N router.
// Response codes, FSM state encodings, and index-width helper.
// Imported by the decoder and the router top.
package axi_lite_router_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {W_IDLE, W_FWD, W_RESP, W_ERR, W_DONE} w_state_t;
  typedef enum logic [2:0] {R_IDLE, R_FWD, R_WAIT, R_ERR, R_DONE} r_state_t;

  // Slave index width; a single-slave router still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_router_if.sv
// Upstream AXI-Lite port plus N packed downstream ports of the router.
// Modport "slave" is the router's view (it is the slave of the core);
// modport "master" is the environment: the core plus the peripherals.
interface axi_lite_router_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 4
);
  localparam int STRB_W = DATA_W / 8;

  // upstream
  logic [ADDR_W-1:0] s_axi_lite_awaddr;
  logic              s_axi_lite_awvalid;
  logic              s_axi_lite_awready;
  logic [DATA_W-1:0] s_axi_lite_wdata;
  logic [STRB_W-1:0] s_axi_lite_wstrb;
  logic              s_axi_lite_wvalid;
  logic              s_axi_lite_wready;
  logic [1:0]        s_axi_lite_bresp;
  logic              s_axi_lite_bvalid;
  logic              s_axi_lite_bready;
  logic [ADDR_W-1:0] s_axi_lite_araddr;
  logic              s_axi_lite_arvalid;
  logic              s_axi_lite_arready;
  logic [DATA_W-1:0] s_axi_lite_rdata;
  logic [1:0]        s_axi_lite_rresp;
  logic              s_axi_lite_rvalid;
  logic              s_axi_lite_rready;

  // downstream, one lane per slave
  logic [N_SLAVES-1:0][ADDR_W-1:0] m_axi_lite_awaddr;
  logic [N_SLAVES-1:0]             m_axi_lite_awvalid;
  logic [N_SLAVES-1:0]             m_axi_lite_awready;
  logic [N_SLAVES-1:0][DATA_W-1:0] m_axi_lite_wdata;
  logic [N_SLAVES-1:0][STRB_W-1:0] m_axi_lite_wstrb;
  logic [N_SLAVES-1:0]             m_axi_lite_wvalid;
  logic [N_SLAVES-1:0]             m_axi_lite_wready;
  logic [N_SLAVES-1:0][1:0]        m_axi_lite_bresp;
  logic [N_SLAVES-1:0]             m_axi_lite_bvalid;
  logic [N_SLAVES-1:0]             m_axi_lite_bready;
  logic [N_SLAVES-1:0][ADDR_W-1:0] m_axi_lite_araddr;
  logic [N_SLAVES-1:0]             m_axi_lite_arvalid;
  logic [N_SLAVES-1:0]             m_axi_lite_arready;
  logic [N_SLAVES-1:0][DATA_W-1:0] m_axi_lite_rdata;
  logic [N_SLAVES-1:0][1:0]        m_axi_lite_rresp;
  logic [N_SLAVES-1:0]             m_axi_lite_rvalid;
  logic [N_SLAVES-1:0]             m_axi_lite_rready;

  modport slave (
    input  s_axi_lite_awaddr, s_axi_lite_awvalid, output s_axi_lite_awready,
    input  s_axi_lite_wdata, s_axi_lite_wstrb, s_axi_lite_wvalid, output s_axi_lite_wready,
    output s_axi_lite_bresp, s_axi_lite_bvalid, input s_axi_lite_bready,
    input  s_axi_lite_araddr, s_axi_lite_arvalid, output s_axi_lite_arready,
    output s_axi_lite_rdata, s_axi_lite_rresp, s_axi_lite_rvalid, input s_axi_lite_rready,
    output m_axi_lite_awaddr, m_axi_lite_awvalid, input m_axi_lite_awready,
    output m_axi_lite_wdata, m_axi_lite_wstrb, m_axi_lite_wvalid, input m_axi_lite_wready,
    input  m_axi_lite_bresp, m_axi_lite_bvalid, output m_axi_lite_bready,
    output m_axi_lite_araddr, m_axi_lite_arvalid, input m_axi_lite_arready,
    input  m_axi_lite_rdata, m_axi_lite_rresp, m_axi_lite_rvalid, output m_axi_lite_rready
  );

  modport master (
    output s_axi_lite_awaddr, s_axi_lite_awvalid, input s_axi_lite_awready,
    output s_axi_lite_wdata, s_axi_lite_wstrb, s_axi_lite_wvalid, input s_axi_lite_wready,
    input  s_axi_lite_bresp, s_axi_lite_bvalid, output s_axi_lite_bready,
    output s_axi_lite_araddr, s_axi_lite_arvalid, input s_axi_lite_arready,
    input  s_axi_lite_rdata, s_axi_lite_rresp, s_axi_lite_rvalid, output s_axi_lite_rready,
    input  m_axi_lite_awaddr, m_axi_lite_awvalid, output m_axi_lite_awready,
    input  m_axi_lite_wdata, m_axi_lite_wstrb, m_axi_lite_wvalid, output m_axi_lite_wready,
    output m_axi_lite_bresp, m_axi_lite_bvalid, input m_axi_lite_bready,
    input  m_axi_lite_araddr, m_axi_lite_arvalid, output m_axi_lite_arready,
    output m_axi_lite_rdata, m_axi_lite_rresp, m_axi_lite_rvalid, input m_axi_lite_rready
  );

endinterface

// File: rtl/axi_lite_addr_decode.sv
// Address decoder: slave i hits when (addr & mask[i]) == base[i].
// Purely combinational; lowest matching index wins.
// hit=0 flags an unmapped address.
module axi_lite_addr_decode
  import axi_lite_router_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int N_SLAVES = 4,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLV_MASK = '0,
  localparam int IDX_W = idx_width(N_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              hit
);

  // Scan from the top so the lowest matching index is written last.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i]) == SLV_BASE[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/axi_lite_router.sv
// 1-to-N AXI-Lite router with independent write and read FSMs, one transaction each.
// Address accept to downstream valid is one cycle; responses return one cycle after the slave.
// Unmapped addresses complete locally with DECERR, so the core is never stalled by a missing slave.
module axi_lite_router
  import axi_lite_router_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 4,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic               clk,
  input  logic               rst,
  axi_lite_router_if.slave   bus,
  output logic               busy_w,
  output logic               busy_r
);

  localparam int IDX_W = idx_width(N_SLAVES);

  w_state_t          w_state;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [IDX_W-1:0]  w_sel;
  logic              aw_done;
  logic              w_done;
  logic [1:0]        bresp_q;

  r_state_t          r_state;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [IDX_W-1:0]  r_sel;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  logic [IDX_W-1:0]  aw_idx, ar_idx;
  logic              aw_hit, ar_hit;
  logic              aw_fire, w_fire;

  axi_lite_addr_decode #(
    .ADDR_W(ADDR_W), .N_SLAVES(N_SLAVES), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_aw_dec (
    .addr(bus.s_axi_lite_awaddr), .idx(aw_idx), .hit(aw_hit)
  );

  axi_lite_addr_decode #(
    .ADDR_W(ADDR_W), .N_SLAVES(N_SLAVES), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_ar_dec (
    .addr(bus.s_axi_lite_araddr), .idx(ar_idx), .hit(ar_hit)
  );

  // Downstream AW and W handshakes on the selected lane, tracked separately.
  assign aw_fire = (w_state == W_FWD) && !aw_done && bus.m_axi_lite_awready[w_sel];
  assign w_fire  = (w_state == W_FWD) && !w_done && bus.s_axi_lite_wvalid
                   && bus.m_axi_lite_wready[w_sel];

  // Write FSM: latch/decode address, forward AW+W, collect B, hand it back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      w_sel     <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (bus.s_axi_lite_awvalid) begin
          aw_addr_q <= bus.s_axi_lite_awaddr;
          w_sel     <= aw_idx;
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
          w_state   <= aw_hit ? W_FWD : W_ERR;
        end
        W_FWD: begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
          if ((aw_done || aw_fire) && (w_done || w_fire)) w_state <= W_RESP;
        end
        W_RESP: if (bus.m_axi_lite_bvalid[w_sel]) begin
          bresp_q <= bus.m_axi_lite_bresp[w_sel];
          w_state <= W_DONE;
        end
        W_ERR: if (bus.s_axi_lite_wvalid) begin
          bresp_q <= RESP_DECERR;
          w_state <= W_DONE;
        end
        W_DONE: if (bus.s_axi_lite_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: latch/decode address, forward AR, capture R, hand it back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_IDLE;
      ar_addr_q <= '0;
      r_sel     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: if (bus.s_axi_lite_arvalid) begin
          ar_addr_q <= bus.s_axi_lite_araddr;
          r_sel     <= ar_idx;
          r_state   <= ar_hit ? R_FWD : R_ERR;
        end
        R_FWD: if (bus.m_axi_lite_arready[r_sel]) r_state <= R_WAIT;
        R_WAIT: if (bus.m_axi_lite_rvalid[r_sel]) begin
          rdata_q <= bus.m_axi_lite_rdata[r_sel];
          rresp_q <= bus.m_axi_lite_rresp[r_sel];
          r_state <= R_DONE;
        end
        R_ERR: begin
          rdata_q <= '0;
          rresp_q <= RESP_DECERR;
          r_state <= R_DONE;
        end
        R_DONE: if (bus.s_axi_lite_rready) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Upstream handshakes decoded from state; address ready is held low during reset.
  always_comb begin
    bus.s_axi_lite_awready = (w_state == W_IDLE) && !rst;
    bus.s_axi_lite_wready  = 1'b0;
    if (w_state == W_ERR) begin
      bus.s_axi_lite_wready = 1'b1;
    end else if (w_state == W_FWD && !w_done) begin
      bus.s_axi_lite_wready = bus.m_axi_lite_wready[w_sel];
    end
    bus.s_axi_lite_bvalid  = (w_state == W_DONE);
    bus.s_axi_lite_bresp   = bresp_q;
    bus.s_axi_lite_arready = (r_state == R_IDLE) && !rst;
    bus.s_axi_lite_rvalid  = (r_state == R_DONE);
    bus.s_axi_lite_rdata   = rdata_q;
    bus.s_axi_lite_rresp   = rresp_q;
    busy_w = (w_state != W_IDLE);
    busy_r = (r_state != R_IDLE);
  end

  // Downstream lanes: payload broadcast, valid/ready only on the selected lane.
  always_comb begin
    for (int i = 0; i < N_SLAVES; i++) begin
      bus.m_axi_lite_awaddr[i]  = aw_addr_q;
      bus.m_axi_lite_wdata[i]   = bus.s_axi_lite_wdata;
      bus.m_axi_lite_wstrb[i]   = bus.s_axi_lite_wstrb;
      bus.m_axi_lite_araddr[i]  = ar_addr_q;
      bus.m_axi_lite_awvalid[i] = (w_sel == IDX_W'(i)) && (w_state == W_FWD) && !aw_done;
      bus.m_axi_lite_wvalid[i]  = (w_sel == IDX_W'(i)) && (w_state == W_FWD) && !w_done
                                  && bus.s_axi_lite_wvalid;
      bus.m_axi_lite_bready[i]  = (w_sel == IDX_W'(i)) && (w_state == W_RESP);
      bus.m_axi_lite_arvalid[i] = (r_sel == IDX_W'(i)) && (r_state == R_FWD);
      bus.m_axi_lite_rready[i]  = (r_sel == IDX_W'(i)) && (r_state == R_WAIT);
    end
  end

endmodule

// File: doc/axi_lite_router.md
# axi_lite_router

Parametrised 1-to-N AXI-Lite router between the core's single AXI-Lite master port and N peripheral slaves, with all channels exposed as discrete signals for Vivado block-design integration. Addresses are decoded against per-slave base/mask pairs. The block runs one write FSM and one read FSM, each allowing one transaction in flight. It returns DECERR for unmapped addresses and never stalls the core indefinitely on an unmapped access.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8); strobe width is DATA_W/8
- N_SLAVES, 4, number of downstream ports (1..16)
- SLV_BASE, {N_SLAVES{ADDR_W'0}}, packed array of per-slave base addresses
- SLV_MASK, {N_SLAVES{ADDR_W'0}}, packed array of per-slave compare masks
- clk  in  1  core clock; all logic in this single domain
- rst  in  1  reset, asynchronous, active-high
- s_axi_lite_aw{addr,valid,ready}  in/in/out  ADDR_W/1/1  upstream write address
- s_axi_lite_w{data,strb,valid,ready}  in/in/in/out  DATA_W/DATA_W/8/1/1  upstream write data
- s_axi_lite_b{resp,valid,ready}  out/out/in  2/1/1  upstream write response
- s_axi_lite_ar{addr,valid,ready}  in/in/out  ADDR_W/1/1  upstream read address
- s_axi_lite_r{data,resp,valid,ready}  out/out/out/in  DATA_W/2/1/1  upstream read data
- m_axi_lite_*  mirrored directions  [N_SLAVES-1:0][width]  same five channels per slave, packed arrays
- busy_w, busy_r  out  1  write/read FSM not idle (debug)

## Operation
- Decode: slave i matches when (addr & SLV_MASK[i]) == SLV_BASE[i]. The lowest matching index wins. No match means decode error.
- Write FSM states:
  - W_IDLE: s_awready=1. On awvalid, latch addr, decode, and latch the index. Go to W_FWD, or to W_ERR on decode error.
  - W_FWD: drive m_awvalid[sel] from the latched addr until m_awready. Pass wvalid, wdata and wstrb through to sel, and drive s_wready=m_wready[sel], until the W handshake completes. AW and W handshakes are tracked independently and may complete in either order or the same cycle. When both are done, go to W_RESP.
  - W_RESP: m_bready[sel]=1. On m_bvalid[sel], capture bresp and go to W_DONE.
  - W_ERR: s_wready=1. On the W handshake, write data is discarded, bresp=2'b11, and the FSM goes to W_DONE.
  - W_DONE: s_bvalid=1 with the captured bresp. On s_bready, go to W_IDLE.
- Read FSM states:
  - R_IDLE: s_arready=1. Latch and decode, then go to R_FWD, or to R_ERR on decode error.
  - R_FWD: drive m_arvalid[sel] until m_arready, then go to R_WAIT.
  - R_WAIT: m_rready[sel]=1. Capture rdata/rresp, then go to R_DONE.
  - R_ERR: rdata=0, rresp=2'b11, go to R_DONE.
  - R_DONE: s_rvalid=1. On s_rready, go to R_IDLE.
- Read and write FSMs are fully independent; both may target the same slave concurrently.
- Only the selected slave sees valid/ready asserted; all other ports hold valid=0 and ready=0.
- Slave bresp/rresp values (OKAY, SLVERR) are forwarded unmodified.

## Timing
- Reset values:
  - all *valid and *ready outputs 0, including s_awready and s_arready while rst=1
  - captured data/resp registers 0
  - both FSMs in IDLE; busy_w=busy_r=0
- Reset mid-transaction: asynchronous return to IDLE. The outstanding transaction is dropped with no response.
- Latency (0-wait-state slave):
  - AW accept cycle t gives m_awvalid at t+1.
  - Slave bvalid at cycle k gives s_bvalid at k+1.
  - Read: ar accept t, m_arvalid t+1, s_rvalid one cycle after m_rvalid.
- Decode-error latency:
  - read: s_rvalid 2 cycles after ar accept
  - write: s_bvalid 1 cycle after the W handshake
- All *valid outputs hold stable, with stable payload, until their handshake completes.
- s_wready is combinational from m_wready[sel]. All other outputs are registered or decoded directly from state.

## Structure
- Package axi_lite_router_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - typedef enum w_state_t {W_IDLE, W_FWD, W_RESP, W_ERR, W_DONE}
  - typedef enum r_state_t {R_IDLE, R_FWD, R_WAIT, R_ERR, R_DONE}
- Sub-module axi_lite_addr_decode: combinational, parametrised on the same generics. Outputs the index ($clog2(N_SLAVES) bits) and a hit flag. It is instantiated twice, once for AW and once for AR.

## Test plan
- N_SLAVES=4, SLV_BASE[2]=0x1000_0000, SLV_MASK=0xF000_0000:
  - write 0x1000_0004 data 0xDEADBEEF strb 0xF → only port 2 sees the AW and W handshakes; s_bresp=OKAY.
- Read 0x1000_0004 with slave returning 0x12345678 and rresp 2'b10 → s_rdata=0x12345678, s_rresp=2'b10, other ports idle.
- Write to 0x9000_0000 (unmapped):
  - no m_* valid asserted on any port
  - s_bresp=2'b11 one cycle after the W handshake
- Read to 0x9000_0000 (unmapped) → s_rvalid 2 cycles after ar accept, rdata=0, rresp=2'b11.
- W presented 3 cycles before AW, slave awready delayed 5 cycles, s_bready held low 4 cycles:
  - single transfer completes
  - s_bvalid and s_bresp stable throughout
  - simultaneous read to another slave completes unaffected
- rst asserted while in W_RESP → all outputs 0 immediately; after release, a new write to slave 0 completes normally.
